// File: rtl/axi4_mgr_sched_pkg.sv
// axi4_mgr_sched_pkg: shared types and constants for the axi4_mgr request scheduler
package axi4_mgr_sched_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;
  localparam int RSP_WR_BIT = 0;
  localparam int RSP_RD_BIT = 1;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi4_mgr_sched_rr.sv
// rr_arbiter_comb: combinational round-robin pick, first set bit at or after ptr
module rr_arbiter_comb #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);
  localparam int W = $clog2(N);
  // scan from farthest to nearest so the nearest requester at/after ptr wins
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[W'((int'(ptr) + i) % N)]) begin
        gnt = '0;
        gnt[W'((int'(ptr) + i) % N)] = 1'b1;
        idx = W'((int'(ptr) + i) % N);
      end
  end
endmodule

// File: rtl/axi4_mgr_sched.sv
// axi4_mgr_sched: round-robin scheduler sharing one axi4_mgr between requesters
module axi4_mgr_sched
  import axi4_mgr_sched_pkg::*;
#(
  parameter int NUM_REQ          = 2,
  parameter int AXI4_ADDR_WIDTH  = 32,
  parameter int DATA_COUNT_WIDTH = 8,
  parameter int TIMEOUT_CYCLES   = 4096
) (
  input  logic                                  clk_i,
  input  logic                                  rstn_i,
  input  logic [NUM_REQ-1:0]                    req_valid_i,
  output logic [NUM_REQ-1:0]                    req_ready_o,
  input  logic [NUM_REQ-1:0]                    req_rd_i,
  input  logic [NUM_REQ*AXI4_ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ*DATA_COUNT_WIDTH-1:0]   req_count_i,
  output logic [NUM_REQ-1:0]                    rsp_valid_o,
  output logic [1:0]                            rsp_err_o,
  output logic [1:0]                            mgr_req_o,
  output logic [AXI4_ADDR_WIDTH-1:0]            mgr_wr_addr_o,
  output logic [AXI4_ADDR_WIDTH-1:0]            mgr_rd_addr_o,
  output logic [DATA_COUNT_WIDTH-1:0]           mgr_rd_count_o,
  input  logic [1:0]                            mgr_rsp_i,
  input  logic [1:0]                            mgr_wr_err_i,
  input  logic [1:0]                            mgr_rd_err_i,
  output logic                                  busy_o,
  output logic                                  timeout_o,
  input  logic                                  timeout_clr_i
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  sched_state_e                state;
  logic [PW-1:0]               ptr, owner, win_idx;
  logic [NUM_REQ-1:0]          win_gnt;
  logic                        rd_q, done, expired;
  logic [AXI4_ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_COUNT_WIDTH-1:0] count_q;
  logic [1:0]                  err_q;
  logic [TW-1:0]               cnt;
  rr_arbiter_comb #(.N(NUM_REQ)) u_arb (
    .req(req_valid_i),
    .ptr(ptr),
    .gnt(win_gnt),
    .idx(win_idx)
  );
  assign done    = rd_q ? mgr_rsp_i[RSP_RD_BIT] : mgr_rsp_i[RSP_WR_BIT];
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt == TW'(TIMEOUT_CYCLES - 1));
  // ready is masked by reset so every output reads 0 while rstn_i is low
  assign req_ready_o    = (state == IDLE && rstn_i) ? win_gnt : '0;
  assign mgr_req_o      = (state == ISSUE) ? (rd_q ? 2'b10 : 2'b01) : 2'b00;
  assign mgr_wr_addr_o  = (state != IDLE) ? addr_q : '0;
  assign mgr_rd_addr_o  = (state != IDLE) ? addr_q : '0;
  assign mgr_rd_count_o = (state != IDLE) ? count_q : '0;
  assign rsp_valid_o    = (state == RESP) ? NUM_REQ'(1) << owner : '0;
  assign rsp_err_o      = (state == RESP) ? err_q : 2'b00;
  assign busy_o         = state != IDLE;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      count_q   <= '0;
      err_q     <= 2'b00;
      cnt       <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (timeout_clr_i) timeout_o <= 1'b0;
      case (state)
        IDLE: if (|req_valid_i) begin
          owner   <= win_idx;
          rd_q    <= req_rd_i[win_idx];
          addr_q  <= req_addr_i[win_idx*AXI4_ADDR_WIDTH +: AXI4_ADDR_WIDTH];
          count_q <= req_count_i[win_idx*DATA_COUNT_WIDTH +: DATA_COUNT_WIDTH];
          state   <= ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        // completion is checked before expiry so a coincident response still wins
        WAIT: if (done) begin
          err_q <= rd_q ? mgr_rd_err_i : mgr_wr_err_i;
          state <= RESP;
        end else if (expired) begin
          err_q     <= AXI_RESP_SLVERR;
          timeout_o <= 1'b1;
          state     <= RESP;
        end else
          cnt <= (cnt == TW'(TIMEOUT_CYCLES)) ? cnt : cnt + 1'b1;
        RESP: begin
          ptr   <= (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_mgr_sched.sv
// tb_axi4_mgr_sched: table-driven and scoreboarded checks of the axi4_mgr scheduler
module tb_axi4_mgr_sched;
  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [1:0]  req_valid_i, req_ready_o, req_rd_i, rsp_valid_o, rsp_err_o;
  logic [63:0] req_addr_i;
  logic [15:0] req_count_i;
  logic [1:0]  mgr_req_o, mgr_rsp_i, mgr_wr_err_i, mgr_rd_err_i;
  logic [31:0] mgr_wr_addr_o, mgr_rd_addr_o;
  logic [7:0]  mgr_rd_count_o;
  logic        busy_o, timeout_o, timeout_clr_i;
  int asserts = 0;
  int fails = 0;
  int cyc = 0;
  typedef struct {
    int         r;
    bit         rd;
    logic [31:0] addr;
    logic [7:0] cnt;
    int         delay;
    bit         wrong;
    logic [1:0] err;
    logic [1:0] exp_err;
  } vec_t;
  typedef struct {
    logic [1:0] v;
    logic [1:0] e;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[6];
  axi4_mgr_sched #(
    .NUM_REQ(2),
    .AXI4_ADDR_WIDTH(32),
    .DATA_COUNT_WIDTH(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_rd_i(req_rd_i),
    .req_addr_i(req_addr_i),
    .req_count_i(req_count_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_err_o(rsp_err_o),
    .mgr_req_o(mgr_req_o),
    .mgr_wr_addr_o(mgr_wr_addr_o),
    .mgr_rd_addr_o(mgr_rd_addr_o),
    .mgr_rd_count_o(mgr_rd_count_o),
    .mgr_rsp_i(mgr_rsp_i),
    .mgr_wr_err_i(mgr_wr_err_i),
    .mgr_rd_err_i(mgr_rd_err_i),
    .busy_o(busy_o),
    .timeout_o(timeout_o),
    .timeout_clr_i(timeout_clr_i)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  always @(negedge clk_i)
    if (rstn_i) check("ready_onehot_req_legal", {62'd0, $onehot0(req_ready_o), mgr_req_o != 2'b11}, 64'd3);
  function automatic exp_t pop_exp();
    exp_t e;
    e = '{2'b11, 2'b11};
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction
  task automatic do_xfer(input vec_t t);
    int n, c_acc, c_iss;
    exp_t e;
    @(posedge clk_i); #1;
    req_valid_i = '0;
    req_valid_i[t.r] = 1'b1;
    req_rd_i[t.r] = t.rd;
    req_addr_i[t.r*32 +: 32] = t.addr;
    req_count_i[t.r*8 +: 8] = t.cnt;
    n = 0;
    @(negedge clk_i);
    while (req_ready_o == 2'b00 && n < 50) begin @(negedge clk_i); n++; end
    check("grant", {62'd0, req_ready_o}, 64'd1 << t.r);
    c_acc = cyc;
    sb.push_back('{2'(1 << t.r), t.exp_err});
    @(posedge clk_i); #1;
    req_valid_i = '0;
    @(negedge clk_i);
    check("issue_req", {62'd0, mgr_req_o}, t.rd ? 64'd2 : 64'd1);
    check("issue_addr", {32'd0, t.rd ? mgr_rd_addr_o : mgr_wr_addr_o}, {32'd0, t.addr});
    if (t.rd) check("issue_count", {56'd0, mgr_rd_count_o}, {56'd0, t.cnt});
    c_iss = cyc;
    if (t.delay >= 0) begin
      @(posedge clk_i); #1;
      if (t.wrong) begin
        mgr_rsp_i = t.rd ? 2'b01 : 2'b10;
        mgr_wr_err_i = 2'b11;
        mgr_rd_err_i = 2'b11;
        @(posedge clk_i); #1;
        mgr_rsp_i = 2'b00;
        @(negedge clk_i);
        check("wrong_bit_ignored", {61'd0, busy_o, rsp_valid_o}, 64'h4);
        @(posedge clk_i); #1;
      end
      repeat (t.delay) @(posedge clk_i);
      #1;
      mgr_rsp_i = t.rd ? 2'b10 : 2'b01;
      mgr_rd_err_i = t.rd ? t.err : ~t.err;
      mgr_wr_err_i = t.rd ? ~t.err : t.err;
      @(posedge clk_i); #1;
      mgr_rsp_i = 2'b00;
      mgr_rd_err_i = 2'b00;
      mgr_wr_err_i = 2'b00;
    end
    n = 0;
    @(negedge clk_i);
    while (rsp_valid_o == 2'b00 && n < 40) begin @(negedge clk_i); n++; end
    e = pop_exp();
    check("rsp_valid", {62'd0, rsp_valid_o}, {62'd0, e.v});
    check("rsp_err", {62'd0, rsp_err_o}, {62'd0, e.e});
    if (t.delay >= 0) begin
      check("latency", 64'(cyc - c_acc), 64'(3 + t.delay + (t.wrong ? 2 : 0)));
      check("no_timeout", {63'd0, timeout_o}, 64'd0);
    end else begin
      check("timeout_window", {63'd0, (cyc - c_iss >= 16) && (cyc - c_iss <= 18)}, 64'd1);
      check("timeout_flag", {63'd0, timeout_o}, 64'd1);
    end
    @(negedge clk_i);
    check("rsp_one_pulse", {62'd0, rsp_valid_o}, 64'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    exp_t e;
    tbl[0] = '{0, 1'b0, 32'h0000_1000, 8'd0,   2,  1'b0, 2'b00, 2'b00};
    tbl[1] = '{1, 1'b1, 32'h0000_2000, 8'd16,  1,  1'b0, 2'b10, 2'b10};
    tbl[2] = '{0, 1'b1, 32'h3000_0040, 8'd255, 0,  1'b0, 2'b01, 2'b01};
    tbl[3] = '{1, 1'b0, 32'hFFFF_FFFC, 8'd3,   4,  1'b0, 2'b11, 2'b11};
    tbl[4] = '{1, 1'b1, 32'h0000_4000, 8'd1,   0,  1'b1, 2'b01, 2'b01};
    tbl[5] = '{0, 1'b0, 32'h0000_5000, 8'd7,   -1, 1'b0, 2'b00, 2'b10};
    rstn_i = 1'b0;
    req_valid_i = 2'b11;
    req_rd_i = 2'b00;
    req_addr_i = '0;
    req_count_i = '0;
    mgr_rsp_i = 2'b00;
    mgr_wr_err_i = 2'b00;
    mgr_rd_err_i = 2'b00;
    timeout_clr_i = 1'b0;
    #7;
    check("reset_outs", {44'd0, req_ready_o, rsp_valid_o, rsp_err_o, mgr_req_o, mgr_rd_count_o, busy_o, timeout_o},
          64'd0);
    check("reset_addrs", {mgr_wr_addr_o, mgr_rd_addr_o}, 64'd0);
    req_valid_i = 2'b00;
    #15 rstn_i = 1'b1;
    for (int i = 0; i < 6; i++) do_xfer(tbl[i]);
    @(posedge clk_i); #1;
    timeout_clr_i = 1'b1;
    @(posedge clk_i); #1;
    timeout_clr_i = 1'b0;
    @(negedge clk_i);
    check("timeout_clr", {63'd0, timeout_o}, 64'd0);
    // reset in WAIT: requester 1 is granted (ptr is 1), then aborted
    @(posedge clk_i); #1;
    req_valid_i = 2'b10;
    req_rd_i = 2'b00;
    req_addr_i[63:32] = 32'h0000_6000;
    n = 0;
    @(negedge clk_i);
    while (req_ready_o == 2'b00 && n < 50) begin @(negedge clk_i); n++; end
    check("rst_pre_grant", {62'd0, req_ready_o}, 64'd2);
    @(posedge clk_i); #1;
    req_valid_i = 2'b00;
    @(posedge clk_i); #2;
    check("rst_pre_busy", {63'd0, busy_o}, 64'd1);
    rstn_i = 1'b0;
    #1;
    check("rst_async_outs", {44'd0, req_ready_o, rsp_valid_o, rsp_err_o, mgr_req_o, mgr_rd_count_o, busy_o, timeout_o},
          64'd0);
    check("rst_async_addrs", {mgr_wr_addr_o, mgr_rd_addr_o}, 64'd0);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("rst_no_rsp", {62'd0, rsp_valid_o}, 64'd0);
    end
    // contention: both held valid, expect alternating grants starting at 0
    @(posedge clk_i); #1;
    req_valid_i = 2'b11;
    req_rd_i = 2'b10;
    req_addr_i = {32'h0000_B000, 32'h0000_A000};
    req_count_i = {8'd9, 8'd4};
    for (int k = 0; k < 4; k++) begin
      n = 0;
      @(negedge clk_i);
      while (req_ready_o == 2'b00 && n < 50) begin @(negedge clk_i); n++; end
      check("contend_grant", {62'd0, req_ready_o}, 64'd1 << (k % 2));
      sb.push_back('{2'(1 << (k % 2)), 2'(k)});
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      mgr_rsp_i = (k % 2) ? 2'b10 : 2'b01;
      mgr_wr_err_i = 2'(k);
      mgr_rd_err_i = 2'(k);
      @(posedge clk_i); #1;
      mgr_rsp_i = 2'b00;
      @(negedge clk_i);
      e = pop_exp();
      check("contend_rsp_valid", {62'd0, rsp_valid_o}, {62'd0, e.v});
      check("contend_rsp_err", {62'd0, rsp_err_o}, {62'd0, e.e});
    end
    req_valid_i = 2'b00;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
